// File: rtl/apb_pkg.sv
// Shared types and constants for the APB slave family.
package apb_pkg;

   typedef enum logic {APB_IDLE, APB_ACCESS} apb_slv_state_e;

   localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_slave_fsm.sv
// APB3 slave handshake: tracks setup/access phases, counts wait states, drives pready.
// state      | meaning
// APB_IDLE   | no transfer in progress; psel here is the setup phase
// APB_ACCESS | transfer selected; counting down wait states until pready
module apb_slave_fsm
   import apb_pkg::*;
#(
   parameter int WAIT_STATES = 0
) (
   input  logic pclk_i,
   input  logic preset_i,
   input  logic psel_i,
   input  logic penable_i,
   output logic pready_o,
   output logic xfer_done_o
);

   apb_slv_state_e          state_q, state_d;
   logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;

   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         state_q <= APB_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pready_o    = 1'b0;
      xfer_done_o = 1'b0;
      unique case (state_q)
         APB_IDLE: begin
            if (psel_i) begin
               state_d = APB_ACCESS;
               cnt_d   = WAIT_CNT_W'(WAIT_STATES);
            end
         end
         APB_ACCESS: begin
            if (!psel_i) begin
               state_d = APB_IDLE;
            end else if (penable_i) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - WAIT_CNT_W'(1);
               end else begin
                  // Reset in the completing cycle must suppress the handshake.
                  pready_o    = !preset_i;
                  xfer_done_o = !preset_i;
                  state_d     = APB_IDLE;
               end
            end
         end
         default: state_d = APB_IDLE;
      endcase
   end

endmodule

// File: rtl/apb_reg_slave.sv
// Parametrised APB3 register bank with read-back, wait states, pslverr and read-only
// hardware-sourced registers.
module apb_reg_slave
   import apb_pkg::*;
#(
   parameter int                     DATA_WIDTH  = 32,
   parameter int                     NUM_REGS    = 4,
   parameter int                     ADDR_WIDTH  = 4,
   parameter int                     WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
   parameter logic [DATA_WIDTH-1:0]  RESET_VAL   = '0
) (
   input  logic                           pclk_i,
   input  logic                           preset_i,
   input  logic                           psel_i,
   input  logic                           penable_i,
   input  logic                           pwrite_i,
   input  logic [ADDR_WIDTH-1:0]          paddr_i,
   input  logic [DATA_WIDTH-1:0]          pwdata_i,
   output logic [DATA_WIDTH-1:0]          prdata_o,
   output logic                           pready_o,
   output logic                           pslverr_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in_i,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out_o
);

   logic                  xfer_done;
   logic [NUM_REGS-1:0]   addr_hit;
   logic                  in_range;
   logic                  ro_hit;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] rd_val;
   logic [DATA_WIDTH-1:0] regs_q  [NUM_REGS];
   logic [DATA_WIDTH-1:0] reg_val [NUM_REGS];

   apb_slave_fsm #(
      .WAIT_STATES (WAIT_STATES)
   ) u_fsm (
      .pclk_i      (pclk_i),
      .preset_i    (preset_i),
      .psel_i      (psel_i),
      .penable_i   (penable_i),
      .pready_o    (pready_o),
      .xfer_done_o (xfer_done)
   );

   // One-hot decode; an all-zero result means paddr lies past the last register.
   always_comb begin
      addr_hit = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (paddr_i == ADDR_WIDTH'(i)) addr_hit[i] = 1'b1;
      end
   end

   assign in_range = |addr_hit;
   assign ro_hit   = |(addr_hit & RO_MASK);
   assign wr_en    = xfer_done && pwrite_i && in_range && !ro_hit;

   always_comb begin
      reg_out_o = '0;
      rd_val    = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_val[i] = RO_MASK[i] ? hw_in_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
         reg_out_o[i*DATA_WIDTH +: DATA_WIDTH] = reg_val[i];
         if (addr_hit[i]) rd_val = reg_val[i];
      end
   end

   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_hit[i]) regs_q[i] <= pwdata_i;
         end
      end
   end

   assign pslverr_o = pready_o && (!in_range || (pwrite_i && ro_hit));
   assign prdata_o  = (pready_o && !pwrite_i) ? rd_val : '0;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: instance A (no wait states, reg 3 read-only) and
// instance B (three wait states, all writable).
module tb_apb_reg_slave;

   localparam logic [31:0] RST_A = 32'h5A5A_0001;
   localparam logic [31:0] RST_B = 32'h0000_0000;

   logic         pclk = 1'b0;
   logic         preset = 1'b0;
   logic         psel = 1'b0;
   logic         penable = 1'b0;
   logic         pwrite = 1'b0;
   logic [3:0]   paddr = '0;
   logic [31:0]  pwdata = '0;
   logic         cur = 1'b0;
   logic [127:0] hw_a;
   logic [127:0] hw_b;

   logic [31:0]  prdata_a, prdata_b;
   logic         pready_a, pready_b, pslverr_a, pslverr_b;
   logic [127:0] reg_out_a, reg_out_b;

   int n_chk  = 0;
   int n_fail = 0;

   int          wc;
   logic [31:0] rd;
   logic        er;

   always #5 pclk = ~pclk;

   apb_reg_slave #(
      .DATA_WIDTH(32), .NUM_REGS(4), .ADDR_WIDTH(4), .WAIT_STATES(0),
      .RO_MASK(4'b1000), .RESET_VAL(RST_A)
   ) dut_a (
      .pclk_i(pclk), .preset_i(preset), .psel_i(psel && !cur), .penable_i(penable),
      .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata_a),
      .pready_o(pready_a), .pslverr_o(pslverr_a), .hw_in_i(hw_a), .reg_out_o(reg_out_a)
   );

   apb_reg_slave #(
      .DATA_WIDTH(32), .NUM_REGS(4), .ADDR_WIDTH(4), .WAIT_STATES(3),
      .RO_MASK(4'b0000), .RESET_VAL(RST_B)
   ) dut_b (
      .pclk_i(pclk), .preset_i(preset), .psel_i(psel && cur), .penable_i(penable),
      .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata_b),
      .pready_o(pready_b), .pslverr_o(pslverr_b), .hw_in_i(hw_b), .reg_out_o(reg_out_b)
   );

   // Called at posedge+1; returns wait cycles seen (-1 on timeout). Leaves psel high
   // so a following call forms a back-to-back transfer.
   task automatic do_xfer(input logic wr, input logic [3:0] a, input logic [31:0] d,
                          output int wcyc, output logic [31:0] rdat, output logic err);
      logic done;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge pclk); #1;
      penable = 1'b1;
      done = 1'b0; wcyc = 0; rdat = 'x; err = 1'bx;
      while (!done && wcyc < 20) begin
         @(negedge pclk);
         if ((cur ? pready_b : pready_a) === 1'b1) begin
            done = 1'b1;
            rdat = cur ? prdata_b : prdata_a;
            err  = cur ? pslverr_b : pslverr_a;
         end else begin
            wcyc++;
         end
         @(posedge pclk); #1;
      end
      if (!done) wcyc = -1;
   endtask

   task automatic bus_idle();
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
   endtask

   task automatic test_reset();
      preset = 1'b1;
      repeat (2) @(posedge pclk);
      #1 preset = 1'b0;
      @(negedge pclk);
      n_chk++;
      if (reg_out_a !== {32'h0000_1234, RST_A, RST_A, RST_A}) begin
         n_fail++; $display("FAIL reset_reg_out_a got=%h exp=%h", reg_out_a, {32'h0000_1234, RST_A, RST_A, RST_A});
      end
      n_chk++;
      if (reg_out_b !== {4{RST_B}}) begin
         n_fail++; $display("FAIL reset_reg_out_b got=%h exp=%h", reg_out_b, {4{RST_B}});
      end
      n_chk++;
      if ({pready_a, pslverr_a, pready_b, pslverr_b} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_handshake got=%b exp=0000", {pready_a, pslverr_a, pready_b, pslverr_b});
      end
      n_chk++;
      if ({prdata_a, prdata_b} !== 64'h0) begin
         n_fail++; $display("FAIL reset_prdata got=%h exp=0", {prdata_a, prdata_b});
      end
      @(posedge pclk); #1;
   endtask

   task automatic test_ws0();
      cur = 1'b0;
      do_xfer(1'b1, 4'd2, 32'hDEAD_BEEF, wc, rd, er);
      bus_idle();
      n_chk++;
      if (wc !== 0 || er !== 1'b0) begin
         n_fail++; $display("FAIL ws0_write wait=%0d err=%b exp wait=0 err=0", wc, er);
      end
      n_chk++;
      if (reg_out_a[95:0] !== {32'hDEAD_BEEF, RST_A, RST_A}) begin
         n_fail++; $display("FAIL ws0_reg_out got=%h exp=%h", reg_out_a[95:0], {32'hDEAD_BEEF, RST_A, RST_A});
      end
      do_xfer(1'b0, 4'd2, 32'h0, wc, rd, er);
      bus_idle();
      n_chk++;
      if (wc !== 0 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
         n_fail++; $display("FAIL ws0_read wait=%0d data=%h err=%b exp 0 deadbeef 0", wc, rd, er);
      end
      @(negedge pclk);
      n_chk++;
      if (prdata_a !== 32'h0) begin
         n_fail++; $display("FAIL ws0_prdata_idle got=%h exp=0", prdata_a);
      end
      @(posedge pclk); #1;
   endtask

   task automatic test_ws3();
      cur = 1'b1;
      do_xfer(1'b1, 4'd1, 32'h1357_2468, wc, rd, er);
      bus_idle();
      n_chk++;
      if (wc !== 3 || er !== 1'b0) begin
         n_fail++; $display("FAIL ws3_write wait=%0d err=%b exp wait=3 err=0", wc, er);
      end
      n_chk++;
      if (reg_out_b !== {RST_B, RST_B, 32'h1357_2468, RST_B}) begin
         n_fail++; $display("FAIL ws3_reg_out got=%h", reg_out_b);
      end
      do_xfer(1'b0, 4'd1, 32'h0, wc, rd, er);
      bus_idle();
      n_chk++;
      if (wc !== 3 || rd !== 32'h1357_2468) begin
         n_fail++; $display("FAIL ws3_read wait=%0d data=%h exp 3 13572468", wc, rd);
      end
   endtask

   task automatic test_ro();
      cur = 1'b0;
      do_xfer(1'b1, 4'd3, 32'hFFFF_0000, wc, rd, er);
      bus_idle();
      n_chk++;
      if (er !== 1'b1) begin
         n_fail++; $display("FAIL ro_write_err got=%b exp=1", er);
      end
      n_chk++;
      if (reg_out_a !== {32'h0000_1234, 32'hDEAD_BEEF, RST_A, RST_A}) begin
         n_fail++; $display("FAIL ro_reg_out got=%h", reg_out_a);
      end
      do_xfer(1'b0, 4'd3, 32'h0, wc, rd, er);
      bus_idle();
      n_chk++;
      if (rd !== 32'h0000_1234 || er !== 1'b0) begin
         n_fail++; $display("FAIL ro_read data=%h err=%b exp 00001234 0", rd, er);
      end
   endtask

   task automatic test_oob();
      cur = 1'b0;
      do_xfer(1'b1, 4'd7, 32'h1111_1111, wc, rd, er);
      bus_idle();
      n_chk++;
      if (er !== 1'b1) begin
         n_fail++; $display("FAIL oob_write_err got=%b exp=1", er);
      end
      do_xfer(1'b1, 4'd4, 32'h2222_2222, wc, rd, er);
      bus_idle();
      n_chk++;
      if (er !== 1'b1) begin
         n_fail++; $display("FAIL oob_write4_err got=%b exp=1", er);
      end
      n_chk++;
      if (reg_out_a !== {32'h0000_1234, 32'hDEAD_BEEF, RST_A, RST_A}) begin
         n_fail++; $display("FAIL oob_reg_out got=%h", reg_out_a);
      end
      do_xfer(1'b0, 4'd7, 32'h0, wc, rd, er);
      bus_idle();
      n_chk++;
      if (rd !== 32'h0 || er !== 1'b1) begin
         n_fail++; $display("FAIL oob_read data=%h err=%b exp 0 1", rd, er);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd0;
      int          w0, w1;
      cur = 1'b0;
      do_xfer(1'b1, 4'd0, 32'h0000_00A0, w0, rd, er);
      do_xfer(1'b1, 4'd1, 32'h0000_00B1, w1, rd, er);
      do_xfer(1'b0, 4'd0, 32'h0, wc, rd0, er);
      bus_idle();
      n_chk++;
      if (w0 !== 0 || w1 !== 0 || wc !== 0) begin
         n_fail++; $display("FAIL b2b_latency waits=%0d,%0d,%0d exp 0,0,0", w0, w1, wc);
      end
      n_chk++;
      if (rd0 !== 32'h0000_00A0 || er !== 1'b0) begin
         n_fail++; $display("FAIL b2b_read data=%h err=%b exp 000000a0 0", rd0, er);
      end
      n_chk++;
      if (reg_out_a !== {32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_00B1, 32'h0000_00A0}) begin
         n_fail++; $display("FAIL b2b_reg_out got=%h", reg_out_a);
      end
   endtask

   task automatic test_abort();
      logic rdy_seen;
      cur = 1'b1;
      // psel dropped during the wait states
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd2; pwdata = 32'h0000_0099;
      @(posedge pclk); #1 penable = 1'b1;
      @(posedge pclk); #1;
      rdy_seen = 1'b0;
      psel = 1'b0; penable = 1'b0;
      repeat (5) begin
         @(negedge pclk);
         if (pready_b !== 1'b0) rdy_seen = 1'b1;
      end
      @(posedge pclk); #1;
      n_chk++;
      if (rdy_seen !== 1'b0 || reg_out_b[95:64] !== RST_B) begin
         n_fail++; $display("FAIL abort_psel pready_seen=%b reg2=%h exp 0 %h", rdy_seen, reg_out_b[95:64], RST_B);
      end
      do_xfer(1'b0, 4'd1, 32'h0, wc, rd, er);
      bus_idle();
      n_chk++;
      if (wc !== 3 || rd !== 32'h1357_2468) begin
         n_fail++; $display("FAIL abort_recover wait=%0d data=%h exp 3 13572468", wc, rd);
      end
      // reset lands on the cycle that would have completed
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd0; pwdata = 32'h0000_0077;
      @(posedge pclk); #1 penable = 1'b1;
      repeat (3) begin @(posedge pclk); #1; end
      preset = 1'b1;
      @(negedge pclk);
      n_chk++;
      if (pready_b !== 1'b0) begin
         n_fail++; $display("FAIL abort_reset_pready got=%b exp=0", pready_b);
      end
      @(posedge pclk); #1;
      preset = 1'b0; psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      n_chk++;
      if (reg_out_b !== {4{RST_B}} || reg_out_a !== {32'h0000_1234, RST_A, RST_A, RST_A}) begin
         n_fail++; $display("FAIL abort_reset_regs b=%h a=%h", reg_out_b, reg_out_a);
      end
      @(posedge pclk); #1;
      do_xfer(1'b1, 4'd3, 32'h0000_3333, wc, rd, er);
      bus_idle();
      n_chk++;
      if (wc !== 3 || reg_out_b[127:96] !== 32'h0000_3333) begin
         n_fail++; $display("FAIL abort_reset_recover wait=%0d reg3=%h exp 3 00003333", wc, reg_out_b[127:96]);
      end
   endtask

   initial begin
      hw_a = {32'h0000_1234, 32'hEEEE_0002, 32'hEEEE_0001, 32'hEEEE_0000};
      hw_b = {4{32'hCCCC_CCCC}};
      @(posedge pclk); #1;
      test_reset();
      test_ws0();
      test_ws3();
      test_ro();
      test_oob();
      test_back_to_back();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
